fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter CW, default 3, count width; SHALL equal log2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  clock, all state updated on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  redirect from branch/jump resolution; discards all entries.
REQ-006 SHALL have port in_valid  input  1  fetch stage presents a word this cycle.
REQ-007 SHALL have port in_instr  input  32  fetched instruction word.
REQ-008 SHALL have port in_pc  input  32  PC of in_instr.
REQ-009 SHALL have port in_ready  output  1  queue can accept; fetch stage holds its PC when low.
REQ-010 SHALL have port out_valid  output  1  head entry is valid.
REQ-011 SHALL have port out_instr  output  32  head instruction.
REQ-012 SHALL have port out_pc  output  32  head PC.
REQ-013 SHALL have port out_ready  input  1  decode stage consumes head this cycle; low while decode stalls.
REQ-014 SHALL have port count  output  CW  number of valid entries.

Function
REQ-015 SHALL be a circular FIFO of DEPTH entries {instr, pc}, with read pointer, write pointer and count registers.
REQ-016 Push SHALL occur when in_valid && in_ready: entry written at write pointer, write pointer +1 mod DEPTH.
REQ-017 Pop SHALL occur when out_valid && out_ready: read pointer +1 mod DEPTH.
REQ-018 Count next-state: push only +1; pop only -1; push and pop in the same cycle, unchanged; neither, unchanged.
REQ-019 in_ready SHALL be (count < DEPTH), a decode of registered state only, with no combinational dependence on out_ready or in_valid.
REQ-020 A full queue SHALL refuse a push even if a pop occurs in the same cycle.
REQ-021 out_valid SHALL be (count != 0), from registered state only.
REQ-022 out_instr/out_pc SHALL drive the head entry when out_valid=1; when the queue is empty they SHALL drive 32'h0000_0000 (nop).
REQ-023 There SHALL be no bypass: a word pushed into an empty queue appears on the outputs in the following cycle (latency 1).
REQ-024 Pointer wrap SHALL be silent: entry order is preserved across the DEPTH-1 to 0 boundary.
REQ-025 flush=1 SHALL set count, read pointer and write pointer to 0 at the next edge.
REQ-026 flush SHALL override push and pop in the same cycle: the word on in_* is discarded.
REQ-027 in_ready SHALL remain combinationally a function of count only, including during a flush cycle.
REQ-028 Entry contents SHALL NOT need clearing on flush; only pointers and count reset.
REQ-029 Popping an empty queue (out_ready=1, out_valid=0) SHALL have no effect.
REQ-030 in_valid with in_ready=0 SHALL have no effect: no entry is written and no pointer moves.
REQ-031 The queue SHALL be synthesizable with no latches; entry storage SHALL be registers written only on push.

Reset
REQ-032 reset=1 at a rising edge SHALL clear count, read pointer and write pointer to 0, regardless of flush, push or pop.
REQ-033 After reset: out_valid=0, out_instr=0, out_pc=0, in_ready=1, count=0.
REQ-034 Reset asserted mid-operation SHALL discard all entries; the first push after reset deasserts appears at the head one cycle later.

Verification
REQ-035 Fill/drain with DEPTH=4: four pushes with pc 0x3000..0x300C and out_ready=0 -> count=4, in_ready=0; then out_ready=1 for four cycles -> out_pc 0x3000, 0x3004, 0x3008, 0x300C in order, then out_valid=0.
REQ-036 Steady stream: push and pop every cycle starting from count=1 -> count stays 1 for 10 cycles; output lags input by one entry; pointers wrap twice with no reordering.
REQ-037 Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> head pops, push refused, count=3; the next cycle accepts the push, count=4.
REQ-038 Flush priority: count=3, flush=1 with in_valid=1, in_pc=0x3040 -> next cycle count=0, out_valid=0, out_instr=0; a push of 0x3040 in the following cycle appears at the head one cycle after that.
REQ-039 Reset over flush: count=2, reset=1 with flush=1 and a push -> count=0, in_ready=1, out_pc=0.
REQ-040 Empty pop/latency: count=0, out_ready=1, push in_instr=0x24080001 -> same cycle out_valid=0; next cycle out_valid=1, out_instr=0x24080001, popped on that edge, count back to 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction/PC queue decoupling the fetch stage from decode.
// Latency 1 from push to head, with no bypass. A word pushed at edge N is visible at the outputs after edge N.
// Backpressure: in_ready = (count < DEPTH), decoded from registered state only.
//   A full queue refuses a push even when the head pops in the same cycle.
//
// Ports:
//   clk, reset            - rising-edge clock; synchronous active-high reset
//   flush                 - redirect; empties the queue at the next edge and overrides push/pop
//   in_valid/in_instr/in_pc/in_ready   - fetch-side handshake
//   out_valid/out_instr/out_pc/out_ready - decode-side handshake; outputs are zero when empty
//   count                 - number of valid entries

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  // Pointer width is log2(DEPTH). Because DEPTH is a power of two,
  // incrementing a pointer wraps modulo DEPTH naturally.
  localparam int PW = CW - 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];

  logic push;
  logic pop;
  logic wr_en;

  // Handshake flags depend only on the registered count.
  // As a result, in_ready has no path from out_ready or in_valid.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  // A flushed word is never stored. Pointers are cleared anyway, so
  // this only avoids a pointless write.
  assign wr_en = push && !flush;

  // When the queue is empty, a nop (all zeros) is driven downstream instead of stale storage.
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : 32'h0000_0000;
  assign out_pc    = out_valid ? pc_q[rd_ptr_q]    : 32'h0000_0000;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset. Validity is tracked entirely by the pointers and the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_q[wr_ptr_q] <= in_instr;
      pc_q[wr_ptr_q]    <= in_pc;
    end
  end

endmodule
